// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/memory control FSM for the lab processor's PC and datapath.
// Optional performance counters are compiled in when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [8:0]       instr_i,
    input  logic             alu_zero_i,
    input  logic             mem_ready_i,
    output logic             pc_reset_o,
    output logic             pc_halt_o,
    output logic [1:0]       branch_type_o,
    output logic             flag_o,
    output logic             ir_load_o,
    output logic             reg_we_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o
);

    // state    | meaning
    // IDLE     | PC parked at start address, waiting for start
    // FETCH    | capture instruction, latch opcode
    // DECODE   | route by opcode
    // EXEC     | single-cycle ALU/CMP/branch, PC advances
    // MEM      | load/store handshake with timeout
    // HALTED   | done; start re-arms to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
    } state_e;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_BR3   = 3'b100;
    localparam logic [2:0] OP_BR6   = 3'b101;
    localparam logic [2:0] OP_CMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [2:0]        opcode_q, opcode_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Operand bits of the instruction are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= 3'b000;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        flag_d   = flag_q;
        err_d    = err_q;
        wait_d   = wait_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                opcode_d = instr_i[8:6];
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (opcode_q == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode_q == OP_CMP) flag_d = alu_zero_i;
                state_d = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_HALTED: begin
                if (start_i) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decodes of state, except the MEM-cycle completion terms on mem_ready.
    always_comb begin
        pc_reset_o    = 1'b0;
        pc_halt_o     = 1'b1;
        branch_type_o = 2'b00;
        ir_load_o     = 1'b0;
        reg_we_o      = 1'b0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pc_reset_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_FETCH: ir_load_o = 1'b1;
            S_DECODE: ;
            S_EXEC: begin
                pc_halt_o = 1'b0;
                reg_we_o  = (opcode_q == OP_ALU);
                case (opcode_q)
                    OP_JMP:  branch_type_o = 2'b01;
                    OP_BR3:  branch_type_o = 2'b10;
                    OP_BR6:  branch_type_o = 2'b11;
                    default: branch_type_o = 2'b00;
                endcase
            end
            S_MEM: begin
                mem_rd_o  = (opcode_q == OP_LOAD);
                mem_wr_o  = (opcode_q == OP_STORE);
                pc_halt_o = ~mem_ready_i;
                reg_we_o  = mem_ready_i && (opcode_q == OP_LOAD);
            end
            S_HALTED: begin
                done_o = 1'b1;
                busy_o = 1'b0;
            end
            default: busy_o = 1'b0;
        endcase
    end

    assign flag_o = flag_q;
    assign err_o  = err_q;

`ifdef PC_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_q, ins_cnt_q;
    logic             retire;

    // HALT retires on leaving DECODE; every other instruction on its PC-advance cycle.
    assign retire = (state_q == S_EXEC)
                 || (state_q == S_MEM && mem_ready_i)
                 || (state_q == S_DECODE && opcode_q == OP_HALT);

    always_ff @(posedge clk) begin
        if (reset || (state_q == S_IDLE && start_i)) begin
            cyc_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            if (busy_o) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (retire) ins_cnt_q <= ins_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_count_o = cyc_cnt_q;
    assign instr_count_o = ins_cnt_q;
`else
    assign cycle_count_o = '0;
    assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-plus-random bench for pc_sequencer: an instruction-level model predicts
// every cycle's outputs from the opcode, cycle position and mem_ready timing.
module tb_pc_sequencer;

    localparam int MT    = 15;
    localparam int CNT_W = 16;
`ifdef PC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_BR3   = 3'b100;
    localparam logic [2:0] OP_BR6   = 3'b101;
    localparam logic [2:0] OP_CMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum int {K_IDLE, K_FETCH, K_DECODE, K_EXEC, K_MEM, K_HALT} kind_e;

    logic             clk = 1'b0;
    logic             reset, start_i, alu_zero_i, mem_ready_i;
    logic [8:0]       instr_i;
    logic             pc_reset_o, pc_halt_o, flag_o, ir_load_o, reg_we_o;
    logic             mem_rd_o, mem_wr_o, busy_o, done_o, err_o;
    logic [1:0]       branch_type_o;
    logic [CNT_W-1:0] cycle_count_o, instr_count_o;

    pc_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .instr_i(instr_i),
        .alu_zero_i(alu_zero_i), .mem_ready_i(mem_ready_i),
        .pc_reset_o(pc_reset_o), .pc_halt_o(pc_halt_o), .branch_type_o(branch_type_o),
        .flag_o(flag_o), .ir_load_o(ir_load_o), .reg_we_o(reg_we_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .cycle_count_o(cycle_count_o), .instr_count_o(instr_count_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    logic             exp_flag, exp_err;
    logic [CNT_W-1:0] exp_icnt, exp_ccnt;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, let the rising edge land.
    task automatic step(input kind_e k, input logic rst, input logic st, input logic [2:0] op,
                        input logic az, input logic mr);
        logic [8:0] ins;
        logic       adv, busy;
        logic [1:0] bt;
        ins = 9'($urandom);
        if (k == K_FETCH) ins[8:6] = op;
        @(negedge clk);
        reset = rst; start_i = st; instr_i = ins; alu_zero_i = az; mem_ready_i = mr;
        #1;
        adv  = (k == K_EXEC) || (k == K_MEM && mr);
        busy = !(k == K_IDLE || k == K_HALT);
        bt   = 2'b00;
        if (k == K_EXEC && op == OP_JMP) bt = 2'b01;
        if (k == K_EXEC && op == OP_BR3) bt = 2'b10;
        if (k == K_EXEC && op == OP_BR6) bt = 2'b11;
        chk("pc_reset", 32'(pc_reset_o), 32'(k == K_IDLE));
        chk("pc_halt", 32'(pc_halt_o), 32'(!adv));
        chk("branch_type", 32'(branch_type_o), 32'(bt));
        chk("ir_load", 32'(ir_load_o), 32'(k == K_FETCH));
        chk("reg_we", 32'(reg_we_o),
            32'((k == K_EXEC && op == OP_ALU) || (k == K_MEM && mr && op == OP_LOAD)));
        chk("mem_rd", 32'(mem_rd_o), 32'(k == K_MEM && op == OP_LOAD));
        chk("mem_wr", 32'(mem_wr_o), 32'(k == K_MEM && op == OP_STORE));
        chk("busy", 32'(busy_o), 32'(busy));
        chk("done", 32'(done_o), 32'(k == K_HALT));
        chk("flag", 32'(flag_o), 32'(exp_flag));
        chk("err", 32'(err_o), 32'(exp_err));
        chk("cycle_count", 32'(cycle_count_o), PERF ? 32'(exp_ccnt) : 32'd0);
        chk("instr_count", 32'(instr_count_o), PERF ? 32'(exp_icnt) : 32'd0);
        if (rst) begin
            exp_flag = 1'b0; exp_err = 1'b0; exp_icnt = '0; exp_ccnt = '0;
        end else if (k == K_IDLE && st) begin
            exp_icnt = '0; exp_ccnt = '0;
        end else if (busy) begin
            exp_ccnt = exp_ccnt + 1'b1;
        end
    endtask

    // k = MEM cycle (1-based) in which mem_ready rises; 0 or >MT means never.
    task automatic run_instr(input logic [2:0] op, input int k, output bit halted);
        logic az;
        halted = 1'b0;
        step(K_FETCH, 1'b0, rb(), op, rb(), rb());
        step(K_DECODE, 1'b0, rb(), op, rb(), rb());
        if (op == OP_HALT) begin
            exp_icnt = exp_icnt + 1'b1;
            halted   = 1'b1;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            halted = 1'b1;
            for (int c = 1; c <= MT; c++) begin
                step(K_MEM, 1'b0, rb(), op, rb(), logic'(c == k));
                if (c == k) begin
                    exp_icnt = exp_icnt + 1'b1;
                    halted   = 1'b0;
                    break;
                end
            end
            if (halted) exp_err = 1'b1;
        end else begin
            az = rb();
            step(K_EXEC, 1'b0, rb(), op, az, rb());
            if (op == OP_CMP) exp_flag = az;
            exp_icnt = exp_icnt + 1'b1;
        end
    endtask

    task automatic rearm();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) step(K_HALT, 1'b0, 1'b0, 3'b000, rb(), rb());
        step(K_HALT, 1'b0, 1'b1, 3'b000, rb(), rb());
        exp_err = 1'b0;
        step(K_IDLE, 1'b0, 1'b0, 3'b000, rb(), rb());
        step(K_IDLE, 1'b0, 1'b1, 3'b000, rb(), rb());
    endtask

    task automatic run_op(input logic [2:0] op, input int k);
        bit h;
        run_instr(op, k, h);
        if (h) rearm();
    endtask

    initial begin
        logic [2:0] op;
        int         k;
        reset = 1'b1; start_i = 1'b0; instr_i = '0; alu_zero_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_flag = 1'b0; exp_err = 1'b0; exp_icnt = '0; exp_ccnt = '0;

        step(K_IDLE, 1'b0, 1'b0, 3'b000, rb(), rb());
        step(K_IDLE, 1'b0, 1'b0, 3'b000, rb(), rb());
        step(K_IDLE, 1'b0, 1'b1, 3'b000, rb(), rb());

        repeat (3) run_op(OP_ALU, 0);
        run_op(OP_CMP, 0);
        run_op(OP_BR3, 0);
        run_op(OP_CMP, 0);
        run_op(OP_BR6, 0);
        run_op(OP_JMP, 0);
        run_op(OP_LOAD, 3);
        run_op(OP_STORE, 1);
        run_op(OP_LOAD, 1);
        run_op(OP_STORE, MT);
        run_op(OP_STORE, 0);
        run_op(OP_HALT, 0);

        // Reset in the middle of a memory wait.
        step(K_FETCH, 1'b0, 1'b0, OP_LOAD, rb(), rb());
        step(K_DECODE, 1'b0, 1'b0, OP_LOAD, rb(), rb());
        step(K_MEM, 1'b0, 1'b0, OP_LOAD, rb(), 1'b0);
        step(K_MEM, 1'b1, 1'b0, OP_LOAD, rb(), 1'b0);
        step(K_IDLE, 1'b0, 1'b0, 3'b000, rb(), rb());
        step(K_IDLE, 1'b0, 1'b1, 3'b000, rb(), rb());

        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_HALT && $urandom_range(0, 3) != 0) op = OP_ALU;
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MT);
            run_op(op, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
